// File: rtl/bp_me_wormhole_mem_resp_arbiter.sv
// Packet-granular arbiter merging per-port mem_resp wormhole flit streams onto one NoC link.
// Optional BP_ME_WH_ARB_FIXED_PRIO_EN: lowest-index source wins instead of round-robin.
module bp_me_wormhole_mem_resp_arbiter #(
    parameter int num_src_p    = 4,
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_src_p*flit_width_p-1:0] src_data_i,
    input  logic [num_src_p-1:0]              src_v_i,
    output logic [num_src_p-1:0]              src_ready_o,
    output logic [flit_width_p-1:0]           link_data_o,
    output logic                              link_v_o,
    input  logic                              link_ready_i,
    output logic [num_src_p-1:0]              grant_o,
    output logic                              busy_o
);

    localparam int ptr_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [flit_width_p-1:0] src_flit [num_src_p];

    genvar gi;
    generate
        for (gi = 0; gi < num_src_p; gi++) begin : g_slice
            assign src_flit[gi] = src_data_i[gi*flit_width_p +: flit_width_p];
        end
    endgenerate

    logic [0:0]             state_q, state_d;
    logic [ptr_w_lp-1:0]    lock_id_q, lock_id_d;
    logic [len_width_p-1:0] flits_left_q, flits_left_d;
    logic                   out_en_q;

`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
    localparam logic [ptr_w_lp-1:0] last_id_lp = ptr_w_lp'(num_src_p - 1);

    logic [ptr_w_lp-1:0] rr_ptr_q, rr_ptr_d;

    // Explicit compare so non-power-of-2 source counts wrap correctly.
    function automatic logic [ptr_w_lp-1:0] wrap_inc(input logic [ptr_w_lp-1:0] id);
        return (id == last_id_lp) ? '0 : id + 1'b1;
    endfunction
`endif

    // Header arbitration: scan from highest offset down so the nearest valid source wins last.
    logic                sel_found;
    logic [ptr_w_lp-1:0] sel_id;
    int                  sel_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_idx   = 0;
        for (int k = num_src_p - 1; k >= 0; k--) begin
`ifdef BP_ME_WH_ARB_FIXED_PRIO_EN
            sel_idx = k;
`else
            sel_idx = int'(rr_ptr_q) + k;
            if (sel_idx >= num_src_p) begin
                sel_idx = sel_idx - num_src_p;
            end
`endif
            if (src_v_i[ptr_w_lp'(sel_idx)]) begin
                sel_found = 1'b1;
                sel_id    = ptr_w_lp'(sel_idx);
            end
        end
    end

    logic                   gnt_en;
    logic [ptr_w_lp-1:0]    gnt_id;
    logic                   fire;
    logic [len_width_p-1:0] hdr_len;

    // out_en_q keeps every output quiet until the first clock edge after reset release.
    assign gnt_id = (state_q == ST_BUSY) ? lock_id_q : sel_id;
    assign gnt_en = out_en_q & ((state_q == ST_BUSY) | sel_found);

    generate
        for (gi = 0; gi < num_src_p; gi++) begin : g_grant
            assign grant_o[gi] = gnt_en & (gnt_id == ptr_w_lp'(gi));
        end
    endgenerate

    assign link_v_o    = gnt_en & src_v_i[gnt_id];
    assign link_data_o = gnt_en ? src_flit[gnt_id] : '0;
    assign src_ready_o = grant_o & {num_src_p{link_ready_i}};
    assign busy_o      = (state_q == ST_BUSY);
    assign fire        = link_v_o & link_ready_i;
    assign hdr_len     = link_data_o[cord_width_p +: len_width_p];

    always_comb begin
        state_d      = state_q;
        lock_id_d    = lock_id_q;
        flits_left_d = flits_left_q;
`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        if (fire) begin
            if (state_q == ST_IDLE) begin
                if (hdr_len != '0) begin
                    state_d      = ST_BUSY;
                    lock_id_d    = sel_id;
                    flits_left_d = hdr_len;
                end
`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
                else begin
                    rr_ptr_d = wrap_inc(sel_id);
                end
`endif
            end else begin
                // Payload flits are counted, never parsed.
                flits_left_d = flits_left_q - 1'b1;
                if (flits_left_q == len_width_p'(1)) begin
                    state_d = ST_IDLE;
`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
                    rr_ptr_d = wrap_inc(lock_id_q);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            lock_id_q    <= '0;
            flits_left_q <= '0;
            out_en_q     <= 1'b0;
`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lock_id_q    <= lock_id_d;
            flits_left_q <= flits_left_d;
            out_en_q     <= 1'b1;
`ifndef BP_ME_WH_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

endmodule
